// File: rtl/mem_stage_wbuf_if.sv
// rtl/mem_stage_wbuf_if.sv - single-port data memory bus between the MEM stage and the data cache
interface mem_stage_wbuf_if #(
  parameter int WIDTH = 16
) ();
  localparam int BE_W = WIDTH / 8;

  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic [BE_W-1:0]  mem_byte_enable;
  logic             data_request;
  logic             write_enable;
  logic [WIDTH-1:0] mem_rdata;
  logic             data_response;

  modport master (
    output mem_address, mem_wdata, mem_byte_enable, data_request, write_enable,
    input  mem_rdata, data_response
  );

  modport slave (
    input  mem_address, mem_wdata, mem_byte_enable, data_request, write_enable,
    output mem_rdata, data_response
  );
endinterface

// File: rtl/mem_stage_wbuf.sv
// rtl/mem_stage_wbuf.sv - LC-3b MEM stage with posted write buffer (STORE_FWD_EN enables store-to-load forwarding)
module mem_stage_wbuf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic [2:0]               op_kind,
  input  logic [WIDTH-1:0]         src_data,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic [WIDTH-1:0]         trap_addr,
  mem_stage_wbuf_if.master         mem,
  output logic [WIDTH-1:0]         mem_output,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_empty
);
  localparam int BE_W  = WIDTH / 8;
  localparam int LG_BE = $clog2(BE_W);
  localparam int LG_D  = $clog2(DEPTH);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_TRAP = 3'd7;

  localparam logic [LG_D-1:0] PTR_ONE  = 1;
  localparam logic [LG_D:0]   CNT_ONE  = 1;
  localparam logic [LG_D:0]   CNT_FULL = (LG_D + 1)'(DEPTH);

  typedef enum logic       {S_FIRST, S_SECOND} stage_t;
  typedef enum logic [1:0] {P_IDLE, P_READ, P_WRITE} port_t;

  stage_t stage_q, stage_nx;
  port_t  port_q, port_nx;

  // pointer fetched by the first access of LDI/STI
  logic [WIDTH-1:0] ptr_q;
  // final read data held while the pipeline refuses to advance
  logic             rd_done_q;
  logic [WIDTH-1:0] hold_q;

  // registered request, stable for the whole transaction
  logic [WIDTH-1:0] req_addr_q;
  logic [WIDTH-1:0] req_wdata_q;
  logic [BE_W-1:0]  req_be_q;

  // posted write buffer
  logic [WIDTH-1:0] wb_addr [DEPTH];
  logic [WIDTH-1:0] wb_data [DEPTH];
  logic [BE_W-1:0]  wb_be   [DEPTH];
  logic [DEPTH-1:0] wb_vld_q;
  logic [LG_D-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LG_D:0]    cnt_q;

  logic             rd_pend, rd_final;
  logic [WIDTH-1:0] rd_addr;
  logic             st_pend;
  logic [WIDTH-1:0] st_addr, st_data;
  logic [BE_W-1:0]  st_be;
  logic [LG_BE-1:0] st_lane, rd_lane;

  logic             hazard, fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic             rd_hit, pop_now, push, full, ready_int, retire;
  logic [WIDTH-1:0] rd_word, rd_shift;

  // decode the op into the access the current stage state needs
  always_comb begin
    rd_pend  = 1'b0;
    rd_final = 1'b0;
    rd_addr  = alu_data;
    st_pend  = 1'b0;
    st_addr  = alu_data;
    st_data  = src_data;
    st_be    = '1;
    st_lane  = alu_data[LG_BE-1:0];
    case (op_kind)
      OP_LDR, OP_LDB: begin
        rd_pend  = 1'b1;
        rd_final = 1'b1;
      end
      OP_TRAP: begin
        rd_pend  = 1'b1;
        rd_final = 1'b1;
        rd_addr  = trap_addr;
      end
      OP_LDI: begin
        rd_pend  = 1'b1;
        rd_final = (stage_q == S_SECOND);
        rd_addr  = (stage_q == S_SECOND) ? ptr_q : alu_data;
      end
      OP_STI: begin
        if (stage_q == S_FIRST) begin
          rd_pend = 1'b1;
        end else begin
          st_pend = 1'b1;
          st_addr = ptr_q;
        end
      end
      OP_STR: st_pend = 1'b1;
      OP_STB: begin
        st_pend = 1'b1;
        st_data = WIDTH'(src_data[7:0]) << {st_lane, 3'b000};
        st_be   = BE_W'(1) << st_lane;
      end
      default: ;
    endcase
    rd_lane = rd_addr[LG_BE-1:0];
  end

  // word-address match of the pending read against buffered stores
  always_comb begin
    hazard   = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_vld_q[i] && (wb_addr[i][WIDTH-1:LG_BE] == rd_addr[WIDTH-1:LG_BE])) begin
        hazard = 1'b1;
      end
    end
`ifdef STORE_FWD_EN
    begin : fwd_search
      logic            found;
      logic [LG_D-1:0] idx, yidx;
      found = 1'b0;
      yidx  = rd_ptr_q;
      // walk oldest to youngest so the last match is the youngest
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + LG_D'(k);
        if (wb_vld_q[idx] && (wb_addr[idx][WIDTH-1:LG_BE] == rd_addr[WIDTH-1:LG_BE])) begin
          found = 1'b1;
          yidx  = idx;
        end
      end
      if (found && (wb_be[yidx] == '1) && rd_pend && !rd_done_q && (port_q != P_READ)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[yidx];
      end
    end
`endif
  end

  assign pop_now = (port_q == P_WRITE) && mem.data_response;
  assign rd_hit  = ((port_q == P_READ) && mem.data_response) || fwd_hit;
  assign full    = (cnt_q == CNT_FULL);
  assign rd_word = rd_done_q ? hold_q : (fwd_hit ? fwd_data : mem.mem_rdata);
  assign rd_shift = rd_word >> {rd_lane, 3'b000};
  assign retire  = ready_int && advance;
  assign push    = st_pend && retire;

  // completion of the current op and the writeback value
  always_comb begin
    ready_int = 1'b0;
    if (op_kind == OP_NONE) begin
      ready_int = 1'b1;
    end else if (st_pend) begin
      ready_int = !full || pop_now;
    end else if (rd_pend) begin
      ready_int = rd_final && (rd_done_q || rd_hit);
    end
    ready      = rst_n && ready_int;
    mem_output = '0;
    if (rst_n && rd_pend && rd_final) begin
      mem_output = (op_kind == OP_LDB) ? {{(WIDTH-8){1'b0}}, rd_shift[7:0]} : rd_word;
    end
  end

  // stage state register
  always_ff @(posedge clk) begin
    if (!rst_n) stage_q <= S_FIRST;
    else        stage_q <= stage_nx;
  end

  // stage next state: pointer fetched moves to the second access, retire restarts
  always_comb begin
    stage_nx = stage_q;
    if (retire) begin
      stage_nx = S_FIRST;
    end else if ((stage_q == S_FIRST) && ((op_kind == OP_LDI) || (op_kind == OP_STI)) && rd_hit) begin
      stage_nx = S_SECOND;
    end
  end

  // port state register
  always_ff @(posedge clk) begin
    if (!rst_n) port_q <= P_IDLE;
    else        port_q <= port_nx;
  end

  // port next state: reads win unless blocked by a buffered store to the same word
  always_comb begin
    port_nx = port_q;
    case (port_q)
      P_IDLE: begin
        if (rd_pend && !rd_done_q && !hazard && !fwd_hit) port_nx = P_READ;
        else if (cnt_q != '0)                              port_nx = P_WRITE;
      end
      P_READ, P_WRITE: begin
        if (mem.data_response) port_nx = P_IDLE;
      end
      default: port_nx = P_IDLE;
    endcase
  end

  // port outputs driven from the registered request
  always_comb begin
    mem.data_request    = rst_n && (port_q != P_IDLE);
    mem.write_enable    = rst_n && (port_q == P_WRITE);
    mem.mem_address     = req_addr_q;
    mem.mem_wdata       = req_wdata_q;
    mem.mem_byte_enable = req_be_q;
  end

  // latch the request when leaving idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '1;
    end else if (port_q == P_IDLE) begin
      if (port_nx == P_READ) begin
        req_addr_q  <= rd_addr;
        req_wdata_q <= '0;
        req_be_q    <= '1;
      end else if (port_nx == P_WRITE) begin
        req_addr_q  <= wb_addr[rd_ptr_q];
        req_wdata_q <= wb_data[rd_ptr_q];
        req_be_q    <= wb_be[rd_ptr_q];
      end
    end
  end

  // pointer capture and held final read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rd_done_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (retire) begin
        rd_done_q <= 1'b0;
      end else if (rd_hit && rd_pend && rd_final) begin
        rd_done_q <= 1'b1;
        hold_q    <= rd_word;
      end
      if (rd_hit && rd_pend && !rd_final && (stage_q == S_FIRST)) begin
        ptr_q <= rd_word;
      end
    end
  end

  // write buffer: pop clears before push so a full-buffer swap keeps the slot valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      wb_vld_q <= '0;
    end else begin
      if (pop_now) begin
        wb_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        wb_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q           <= wr_ptr_q + PTR_ONE;
      end
      if (push && !pop_now)      cnt_q <= cnt_q + CNT_ONE;
      else if (pop_now && !push) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // write buffer payload
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr_q] <= st_addr;
      wb_data[wr_ptr_q] <= st_data;
      wb_be[wr_ptr_q]   <= st_be;
    end
  end

  assign wb_count = cnt_q;
  assign wb_empty = !rst_n || (cnt_q == '0);
endmodule
